// File: rtl/ip_msxbus_pkg.sv
// ip_msxbus_pkg: shared types and constants for the MSX slot bridge.
// Imported by the strobe synchroniser and the bridge top.
package ip_msxbus_pkg;

    localparam int DATA_W = 8;
    localparam int ADR_W  = 16;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        ISSUE    = 3'd2,
        RD_WAIT  = 3'd3,
        RD_DRIVE = 3'd4,
        END_WAIT = 3'd5
    } state_t;

endpackage

// File: rtl/ip_msxbus_sync.sv
// ip_msxbus_sync: synchronises one active-low slot strobe and
// filters it; level goes low only after FILTER_LEN synced lows.
module ip_msxbus_sync
    import ip_msxbus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_n,
    output logic level,
    output logic fall,
    output logic rise
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] chain;
    logic [CW-1:0]          low_cnt;
    logic                   synced;
    logic                   level_nxt;

    assign synced = chain[SYNC_STAGES-1];

    // Metastability chain, preset to the inactive (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], strobe_n};
        end
    end

    // Any synced high releases; the FILTER_LEN-th low asserts.
    always_comb begin
        level_nxt = level;
        if (synced) begin
            level_nxt = 1'b1;
        end else if (low_cnt == LAST) begin
            level_nxt = 1'b0;
        end
    end

    // Low-run counter, filtered level and edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_cnt <= '0;
            level   <= 1'b1;
            fall    <= 1'b0;
            rise    <= 1'b0;
        end else begin
            if (synced) begin
                low_cnt <= '0;
            end else if (low_cnt != LAST) begin
                low_cnt <= low_cnt + CW'(1);
            end
            level <= level_nxt;
            fall  <= level & ~level_nxt;
            rise  <= ~level & level_nxt;
        end
    end

endmodule

// File: rtl/ip_msxbus_bridge.sv
// ip_msxbus_bridge: MSX cartridge slot to internal peripheral bus.
// One transaction per Z80 bus cycle; holds /WAIT for pending reads.
module ip_msxbus_bridge
    import ip_msxbus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2,
    parameter int NUM_CH      = 4,
    parameter int WAIT_EN     = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADR_W-1:0]         adr,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     is_output,
    output logic                     n_wait,
    input  logic                     n_sltsl,
    input  logic                     n_rd,
    input  logic                     n_wr,
    input  logic                     n_ioreq,
    input  logic                     n_mereq,
    output logic [ADR_W-1:0]         bus_address,
    output logic [DATA_W-1:0]        bus_write_data,
    input  logic [NUM_CH-1:0]        bus_cs,
    input  logic [NUM_CH-1:0]        bus_read_ready,
    input  logic [NUM_CH*DATA_W-1:0] bus_read_data,
    output logic [NUM_CH-1:0]        bus_ch,
    output logic                     bus_read,
    output logic                     bus_write,
    output logic                     bus_io,
    output logic                     bus_memory,
    output logic                     timeout
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic WAIT_ON = (WAIT_EN != 0);

    // Strobe index: 0 sltsl, 1 rd, 2 wr, 3 ioreq, 4 mereq.
    logic [4:0] pins;
    logic [4:0] lvl;
    logic [4:0] fall;
    logic [4:0] rise;

    assign pins = {n_mereq, n_ioreq, n_wr, n_rd, n_sltsl};

    for (genvar i = 0; i < 5; i++) begin : g_sync
        ip_msxbus_sync #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_sync (
            .clk     (clk),
            .reset   (reset),
            .strobe_n(pins[i]),
            .level   (lvl[i]),
            .fall    (fall[i]),
            .rise    (rise[i])
        );
    end

    logic unused_ok;
    assign unused_ok = ^{fall[4:3], fall[0], rise};

    state_t                state;
    logic                  is_rd;
    logic                  drive_en;
    logic [CH_W-1:0]       ch_idx;
    logic [TO_W-1:0]       to_cnt;

    logic                  sel_io;
    logic                  sel_mem;
    logic                  start;
    logic [NUM_CH-1:0]     pick_oh;
    logic [CH_W-1:0]       pick_idx;
    logic                  pick_any;
    logic                  rd_ready;
    logic [DATA_W-1:0]     rd_byte;

    assign sel_io  = ~lvl[3];
    assign sel_mem = ~lvl[4] & ~lvl[0];
    assign start   = (fall[1] | fall[2]) & (sel_io | sel_mem);

    assign pick_oh  = bus_cs & (~bus_cs + NUM_CH'(1));
    assign pick_any = |bus_cs;

    // Lowest-index claim wins the channel arbitration.
    always_comb begin
        pick_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (bus_cs[k]) begin
                pick_idx = CH_W'(k);
            end
        end
    end

    assign rd_ready = bus_read_ready[ch_idx];
    assign rd_byte  = bus_read_data[ch_idx*DATA_W +: DATA_W];

    assign is_output = drive_en & ~n_rd;

    // Transaction FSM with its request, wait and data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            is_rd          <= 1'b0;
            drive_en       <= 1'b0;
            ch_idx         <= '0;
            to_cnt         <= '0;
            o_data         <= '0;
            n_wait         <= 1'b1;
            bus_address    <= '0;
            bus_write_data <= '0;
            bus_ch         <= '0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_io         <= 1'b0;
            bus_memory     <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            timeout   <= 1'b0;
            n_wait    <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bus_address    <= adr;
                        bus_write_data <= i_data;
                        is_rd          <= fall[1];
                        bus_io         <= sel_io;
                        bus_memory     <= ~sel_io;
                        state          <= DECODE;
                    end
                end
                DECODE: begin
                    ch_idx <= pick_idx;
                    if (pick_any) begin
                        bus_ch    <= pick_oh;
                        bus_read  <= is_rd;
                        bus_write <= ~is_rd;
                        state     <= ISSUE;
                    end else begin
                        state <= END_WAIT;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    if (!is_rd) begin
                        state <= END_WAIT;
                    end else if (rd_ready) begin
                        o_data   <= rd_byte;
                        drive_en <= 1'b1;
                        state    <= RD_DRIVE;
                    end else begin
                        n_wait <= ~WAIT_ON;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lvl[1]) begin
                        bus_ch     <= '0;
                        bus_io     <= 1'b0;
                        bus_memory <= 1'b0;
                        state      <= IDLE;
                    end else if (rd_ready) begin
                        o_data   <= rd_byte;
                        drive_en <= 1'b1;
                        state    <= RD_DRIVE;
                    end else if (to_cnt == TO_LAST) begin
                        o_data   <= TIMEOUT_DATA;
                        timeout  <= 1'b1;
                        drive_en <= 1'b1;
                        state    <= RD_DRIVE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                        n_wait <= ~WAIT_ON;
                    end
                end
                RD_DRIVE: begin
                    if (lvl[1]) begin
                        drive_en   <= 1'b0;
                        bus_ch     <= '0;
                        bus_io     <= 1'b0;
                        bus_memory <= 1'b0;
                        state      <= IDLE;
                    end
                end
                END_WAIT: begin
                    if (lvl[1] && lvl[2]) begin
                        bus_ch     <= '0;
                        bus_io     <= 1'b0;
                        bus_memory <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_msxbus_bridge.sv
// tb_ip_msxbus_bridge: vector table, corner sequences and random
// slot cycles checked against a cycle-level behavioural model.
module tb_ip_msxbus_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        is_output;
    logic        n_wait;
    logic        n_sltsl, n_rd, n_wr, n_ioreq, n_mereq;
    logic [15:0] bus_address;
    logic [7:0]  bus_write_data;
    logic [3:0]  bus_cs;
    logic [3:0]  bus_read_ready;
    logic [31:0] bus_read_data;
    logic [3:0]  bus_ch;
    logic        bus_read, bus_write, bus_io, bus_memory;
    logic        timeout;

    ip_msxbus_bridge #(
        .SYNC_STAGES(2),
        .FILTER_LEN (2),
        .NUM_CH     (4),
        .WAIT_EN    (1),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .adr           (adr),
        .i_data        (i_data),
        .o_data        (o_data),
        .is_output     (is_output),
        .n_wait        (n_wait),
        .n_sltsl       (n_sltsl),
        .n_rd          (n_rd),
        .n_wr          (n_wr),
        .n_ioreq       (n_ioreq),
        .n_mereq       (n_mereq),
        .bus_address   (bus_address),
        .bus_write_data(bus_write_data),
        .bus_cs        (bus_cs),
        .bus_read_ready(bus_read_ready),
        .bus_read_data (bus_read_data),
        .bus_ch        (bus_ch),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_io        (bus_io),
        .bus_memory    (bus_memory),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observations collected by run_cycle.
    int          n_rdp, n_wrp, n_waitlo, n_to, late_out;
    bit          seen_drive;
    logic [7:0]  got_odata;
    logic [3:0]  got_ch, end_ch;
    logic [15:0] got_adr;
    logic [7:0]  got_wd;
    logic        got_io, got_mem, end_wait;
    logic [7:0]  last_odata;

    typedef struct {
        bit          wr;
        bit          io;
        bit          sl;
        logic [15:0] adr;
        logic [7:0]  wd;
        logic [3:0]  cs;
        int          d;
        logic [3:0]  ch;
        int          wt;
        bit          to;
        bit          drv;
        logic [7:0]  od;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, got, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] cs);
        for (int k = 0; k < 4; k++) begin
            if (cs[k]) return k;
        end
        return -1;
    endfunction

    // One slot cycle: strobe low for a 40-cycle window, ready for
    // the claimed channel from pulse offset d, optional early release.
    task automatic run_cycle(input bit wr, input bit io,
                             input bit sl,
                             input logic [15:0] a,
                             input logic [7:0] wd,
                             input logic [3:0] cs,
                             input int d, input int rel);
        int tgt;
        int off;
        logic [3:0] rdy;
        tgt = lowest(cs);
        n_rdp = 0; n_wrp = 0; n_waitlo = 0; n_to = 0;
        late_out = 0; seen_drive = 0; got_odata = 8'h00;
        got_ch = 4'h0; got_adr = 16'h0; got_wd = 8'h0;
        got_io = 1'b0; got_mem = 1'b0;
        bus_cs = cs;
        bus_read_ready = 4'h0;
        adr = a;
        i_data = wd;
        if (io) begin
            n_ioreq = 1'b0;
        end else begin
            n_mereq = 1'b0;
            n_sltsl = sl;
        end
        @(negedge clk);
        if (wr) n_wr = 1'b0;
        else n_rd = 1'b0;
        off = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (off < 0 && (bus_read || bus_write)) begin
                off = 0;
                got_ch = bus_ch;
                got_adr = bus_address;
                got_wd = bus_write_data;
                got_io = bus_io;
                got_mem = bus_memory;
            end else if (off >= 0) begin
                off++;
            end
            n_rdp += int'(bus_read);
            n_wrp += int'(bus_write);
            if (!n_wait) n_waitlo++;
            if (timeout) n_to++;
            if (is_output && !seen_drive) begin
                seen_drive = 1'b1;
                got_odata = o_data;
            end
            if (rel >= 0 && off == rel) n_rd = 1'b1;
            rdy = 4'($urandom);
            if (tgt >= 0) rdy[tgt] = (off >= 0 && off >= d);
            bus_read_ready = rdy;
        end
        n_rd = 1'b1;
        n_wr = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (is_output) late_out++;
        end
        end_ch = bus_ch;
        end_wait = n_wait;
        n_ioreq = 1'b1;
        n_mereq = 1'b1;
        n_sltsl = 1'b1;
        bus_cs = 4'h0;
        bus_read_ready = 4'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic verify(input string tag, input bit wr,
                          input bit io, input logic [15:0] a,
                          input logic [7:0] wd,
                          input logic [3:0] ech, input int ewt,
                          input bit eto, input bit edrv,
                          input logic [7:0] eod);
        bit hit;
        hit = (ech != 4'h0);
        check({tag, "_rdpulse"}, n_rdp, 32'(hit && !wr));
        check({tag, "_wrpulse"}, n_wrp, 32'(hit && wr));
        check({tag, "_ch"}, got_ch, ech);
        if (hit) begin
            check({tag, "_adr"}, got_adr, a);
            check({tag, "_io"}, got_io, io);
            check({tag, "_mem"}, got_mem, !io);
            if (wr) check({tag, "_wdata"}, got_wd, wd);
        end
        check({tag, "_wait"}, n_waitlo, ewt);
        check({tag, "_tmo"}, n_to, 32'(eto));
        check({tag, "_drive"}, seen_drive, edrv);
        if (edrv) begin
            check({tag, "_odata"}, got_odata, eod);
            last_odata = eod;
        end
        check({tag, "_lateout"}, late_out, 0);
        check({tag, "_endch"}, end_ch, 4'h0);
        check({tag, "_endwait"}, end_wait, 1'b1);
    endtask

    initial begin
        tbl[0] = '{0, 1, 1, 16'h00A0, 8'h00, 4'b0100, 2,
                   4'b0100, 2, 0, 1, 8'h3C};
        tbl[1] = '{1, 0, 0, 16'h4000, 8'h5A, 4'b0110, 0,
                   4'b0010, 0, 0, 0, 8'h00};
        tbl[2] = '{0, 1, 1, 16'h0098, 8'h00, 4'b0000, 0,
                   4'b0000, 0, 0, 0, 8'h00};
        tbl[3] = '{0, 1, 1, 16'h0011, 8'h00, 4'b0001, 100,
                   4'b0001, 16, 1, 1, 8'hFF};
        tbl[4] = '{0, 0, 0, 16'h8000, 8'h00, 4'b1111, 0,
                   4'b0001, 0, 0, 1, 8'h11};
        tbl[5] = '{0, 0, 1, 16'h8000, 8'h00, 4'b1111, 0,
                   4'b0000, 0, 0, 0, 8'h00};
        tbl[6] = '{1, 1, 1, 16'h0099, 8'hA5, 4'b1000, 0,
                   4'b1000, 0, 0, 0, 8'h00};
        tbl[7] = '{0, 1, 1, 16'h0042, 8'h00, 4'b1010, 16,
                   4'b0010, 16, 0, 1, 8'h22};
        tbl[8] = '{0, 1, 1, 16'h0043, 8'h00, 4'b1000, 17,
                   4'b1000, 16, 1, 1, 8'hFF};

        reset = 1'b1;
        adr = 16'h0; i_data = 8'h0;
        n_sltsl = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
        n_ioreq = 1'b1; n_mereq = 1'b1;
        bus_cs = 4'h0; bus_read_ready = 4'h0;
        bus_read_data = 32'h0;
        last_odata = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_odata", o_data, 8'h00);
        check("rst_nwait", n_wait, 1'b1);
        check("rst_isout", is_output, 1'b0);
        check("rst_ch", bus_ch, 4'h0);
        check("rst_rd", bus_read, 1'b0);
        check("rst_wr", bus_write, 1'b0);
        check("rst_io", bus_io, 1'b0);
        check("rst_mem", bus_memory, 1'b0);
        check("rst_tmo", timeout, 1'b0);

        // One-sample n_rd glitch must be filtered away.
        n_ioreq = 1'b0;
        bus_cs = 4'b0001;
        @(negedge clk);
        n_rd = 1'b0;
        @(negedge clk);
        n_rd = 1'b1;
        n_rdp = 0; n_waitlo = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_rdp += int'(bus_read);
            if (!n_wait) n_waitlo++;
        end
        check("glitch_rdpulse", n_rdp, 0);
        check("glitch_wait", n_waitlo, 0);
        n_ioreq = 1'b1;
        bus_cs = 4'h0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            bus_read_data = 32'h443C2211;
            run_cycle(tbl[i].wr, tbl[i].io, tbl[i].sl,
                      tbl[i].adr, tbl[i].wd, tbl[i].cs,
                      tbl[i].d, -1);
            verify($sformatf("vec%0d", i), tbl[i].wr,
                   tbl[i].io, tbl[i].adr, tbl[i].wd, tbl[i].ch,
                   tbl[i].wt, tbl[i].to, tbl[i].drv, tbl[i].od);
        end

        // Read aborted by n_rd release before ready; late ready.
        bus_read_data = 32'h77665544;
        run_cycle(0, 1, 1, 16'h00A1, 8'h00, 4'b0001, 12, 3);
        check("abort_rdpulse", n_rdp, 1);
        check("abort_drive", seen_drive, 1'b0);
        check("abort_tmo", n_to, 0);
        check("abort_odata", o_data, last_odata);
        check("abort_endwait", end_wait, 1'b1);

        for (int i = 0; i < 24; i++) begin
            bit          wr, io, sl, hit;
            logic [15:0] a;
            logic [7:0]  wd, eod;
            logic [3:0]  cs, ech;
            logic [31:0] rdata;
            int          d, tgt, ewt;
            wr = 1'($urandom);
            io = 1'($urandom);
            sl = ($urandom_range(0, 3) == 0);
            a = 16'($urandom);
            wd = 8'($urandom);
            cs = 4'($urandom);
            d = $urandom_range(0, 20);
            rdata = $urandom;
            tgt = lowest(cs);
            hit = (io || !sl) && tgt >= 0;
            ech = hit ? 4'(1 << tgt) : 4'h0;
            ewt = 0;
            eod = 8'h00;
            if (hit && !wr) begin
                ewt = (d < TMO) ? d : TMO;
                eod = (d <= TMO) ? rdata[8*tgt +: 8] : 8'hFF;
            end
            bus_read_data = rdata;
            run_cycle(wr, io, sl, a, wd, cs, d, -1);
            verify($sformatf("rnd%0d", i), wr, io, a, wd, ech,
                   ewt, hit && !wr && d > TMO, hit && !wr, eod);
        end

        // Reset while the CPU is held in a read wait.
        n_ioreq = 1'b0;
        bus_cs = 4'b0100;
        bus_read_ready = 4'h0;
        @(negedge clk);
        n_rd = 1'b0;
        for (int c = 0; c < 30 && n_wait; c++) @(negedge clk);
        check("midrst_wait_seen", n_wait, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_nwait", n_wait, 1'b1);
        check("midrst_isout", is_output, 1'b0);
        check("midrst_ch", bus_ch, 4'h0);
        check("midrst_odata", o_data, 8'h00);
        n_rd = 1'b1;
        n_ioreq = 1'b1;
        bus_cs = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
